dram_req_scheduler: RTL and testbench

- DRAM-side stage directly upstream of the memory controller; it produces `done`, `rdata` and `rdata_valid`, and consumes `pop` and `grant_line`.
- Queues cache read/write requests, models DRAM access latency against a word array, and asserts `done` when read data is ready.
- Holds read data stable until the controller pops it.

---
 rtl/dram_pkg.sv | 27 ++
 rtl/dram_req_scheduler_fifo.sv | 57 +++++
 rtl/dram_req_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_dram_req_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and default configuration for the DRAM request scheduler.
//   dram_state_t : scheduler FSM states
//   dram_req_t   : request record {we, addr, wdata} at the default widths
//   DEF_*        : default parameter values
package dram_pkg;

  localparam int unsigned DEF_ADDR_W         = 8;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_DEPTH          = 4;
  localparam int unsigned DEF_LATENCY        = 8;
  localparam int unsigned DEF_REFRESH_PERIOD = 64;
  localparam int unsigned DEF_REFRESH_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_POP,
    REFRESH
  } dram_state_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } dram_req_t;

endpackage

// File: rtl/dram_req_scheduler_fifo.sv
// req_fifo: synchronous FIFO of request records.
// Ports:
//   clk, rst_n    clock, async active-low reset (pointers/count only)
//   push, wdata   enqueue (ignored when full unless a pop frees the slot)
//   pop, rdata    dequeue; rdata shows the head entry combinationally
//   full, empty   occupancy flags
//   count         occupancy, 0..DEPTH
module req_fifo
  import dram_pkg::*;
#(
  parameter type         T     = dram_req_t,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  T                mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dram_req_scheduler.sv
// dram_req_scheduler: queues read/write requests, models a fixed DRAM
// access latency against a word array and hands read data to the memory
// controller with a done pulse / pop handshake.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                  request enqueue interface
//   grant_line                          1 = bus free, access may progress
//   pop                                 controller consumed read data
//   done                                one-cycle pulse, rdata valid
//   rdata, rdata_valid                  read data, held until pop
//   busy                                FSM active or requests queued
//   q_count                             FIFO occupancy
// Optional: define DRAM_REFRESH_EN for periodic refresh stalls.
module dram_req_scheduler
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned LATENCY        = DEF_LATENCY,
  parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic                     grant_line,
  input  logic                     pop,
  output logic                     done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rdata_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end
  if (LATENCY < 1 || REFRESH_PERIOD < 2 || REFRESH_CYCLES < 1) begin : g_bad_timing
    $error("LATENCY, REFRESH_PERIOD and REFRESH_CYCLES out of range");
  end

  logic [DATA_W-1:0] mem [2**ADDR_W];
  dram_state_t       state;
  req_t              cur;
  req_t              head;
  req_t              in_req;
  logic [CW-1:0]     cnt;
  logic              f_full;
  logic              f_empty;
  logic              issue;
  logic              commit;

  assign in_req    = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = !f_full;
  assign busy      = (state != IDLE) || !f_empty;
  assign commit    = (state == ACCESS) && grant_line && (cnt == '0);

  req_fifo #(
    .T     (req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .wdata (in_req),
    .pop   (issue),
    .rdata (head),
    .full  (f_full),
    .empty (f_empty),
    .count (q_count)
  );

`ifdef DRAM_REFRESH_EN
  localparam int unsigned RPW = $clog2(REFRESH_PERIOD);
  localparam int unsigned RCW = $clog2(REFRESH_CYCLES + 1);

  logic [RPW-1:0] ref_cnt;
  logic           ref_pending;
  logic [RCW-1:0] rcnt;

  // The last REFRESH cycle may issue directly, so a deferred request
  // starts exactly REFRESH_CYCLES cycles later than it otherwise would.
  assign issue = !f_empty && grant_line && !ref_pending &&
                 ((state == IDLE) || (state == REFRESH && rcnt == '0));
`else
  assign issue = !f_empty && grant_line && (state == IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
`ifdef DRAM_REFRESH_EN
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      rcnt        <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DRAM_REFRESH_EN
      if (ref_cnt == RPW'(REFRESH_PERIOD - 1)) begin
        ref_cnt     <= '0;
        ref_pending <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
`endif
      case (state)
        IDLE: begin
`ifdef DRAM_REFRESH_EN
          if (ref_pending) begin
            ref_pending <= 1'b0;
            rcnt        <= RCW'(REFRESH_CYCLES - 1);
            state       <= REFRESH;
          end else
`endif
          if (issue) begin
            cur   <= head;
            cnt   <= CW'(LATENCY - 1);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (grant_line) begin
            if (cnt == '0) begin
              if (cur.we) begin
                state <= IDLE;
              end else begin
                rdata       <= mem[cur.addr];
                done        <= 1'b1;
                rdata_valid <= 1'b1;
                state       <= WAIT_POP;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        WAIT_POP: begin
          if (pop) begin
            rdata_valid <= 1'b0;
            state       <= IDLE;
          end
        end
`ifdef DRAM_REFRESH_EN
        REFRESH: begin
          if (rcnt == '0) begin
            if (issue) begin
              cur   <= head;
              cnt   <= CW'(LATENCY - 1);
              state <= ACCESS;
            end else begin
              state <= IDLE;
            end
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a write only lands on its final ACCESS cycle.
  always_ff @(posedge clk) begin
    if (commit && cur.we) mem[cur.addr] <= cur.wdata;
  end

endmodule

// File: tb/tb_dram_req_scheduler.sv
// Directed self-checking bench for dram_req_scheduler (default parameters).
module tb_dram_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        grant_line;
  logic        pop;
  logic        done;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic [2:0]  q_count;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dram_req_scheduler #(
    .ADDR_W         (8),
    .DATA_W         (32),
    .DEPTH          (4),
    .LATENCY        (8),
    .REFRESH_PERIOD (64),
    .REFRESH_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .grant_line  (grant_line),
    .pop         (pop),
    .done        (done),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .q_count     (q_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 200);
    check("done_seen", done, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    int          cyc;
    int          ndone;
    logic [31:0] exp_q [5];

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    grant_line = 1'b1;
    pop        = 1'b0;

    #12;
    check("rst_done", done, 0);
    check("rst_rvalid", rdata_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ready", req_ready, 1);
    check("rst_qcount", q_count, 0);
    #10 rst_n = 1'b1;   // t=22, first edge after release at t=25

`ifdef DRAM_REFRESH_EN
    // Refresh becomes pending on the 64th edge after release; the read
    // pushed on that same edge is deferred by the 4-cycle refresh.
    repeat (63) @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd9; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) check("ref_busy", busy, 1);
      if (done) ndone++;
    end
    check("ref_no_early_done", ndone, 0);
    tick();
    check("ref_done_late", done, 1);
    check("ref_rvalid", rdata_valid, 1);
    do_pop();
`else
    // Single read after preloading array[5] through a write.
    tick();
    push(1'b1, 8'd5, 32'hDEADBEEF);
    wait_idle();
    push(1'b0, 8'd5, 32'h0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
    end
    check("rd_no_early_done", ndone, 0);
    tick();
    check("rd_done_at_9", done, 1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    check("rd_rvalid", rdata_valid, 1);
    tick(); tick(); tick();
    check("rd_done_pulse", done, 0);
    check("rd_rvalid_held", rdata_valid, 1);
    check("rd_rdata_held", rdata, 32'hDEADBEEF);
    do_pop();
    check("rd_rvalid_cleared", rdata_valid, 0);
    check("rd_idle", busy, 0);

    // Write then read same address: write gives no done, read sees new data.
    push(1'b1, 8'd3, 32'h12345678);
    push(1'b0, 8'd3, 32'h0);
    wait_done(cyc);
    check("raw_latency", cyc, 17);
    check("raw_rdata", rdata, 32'h12345678);
    do_pop();

    // Grant stall for 5 cycles mid-ACCESS.
    push(1'b0, 8'd5, 32'h0);
    tick(); tick(); tick();
    grant_line = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    grant_line = 1'b1;
    wait_done(cyc);
    check("stall_latency", cyc, 6);
    check("stall_rdata", rdata, 32'hDEADBEEF);
    do_pop();

    // FIFO full while the first read waits for pop.
    push(1'b0, 8'd5, 32'h0);
    wait_done(cyc);
    check("full_first_latency", cyc, 9);
    push(1'b0, 8'd3, 32'h0);
    push(1'b0, 8'd5, 32'h0);
    push(1'b0, 8'd3, 32'h0);
    push(1'b0, 8'd5, 32'h0);
    check("full_qcount", q_count, 4);
    check("full_ready_low", req_ready, 0);
    push(1'b1, 8'd5, 32'hBAD0BAD0);
    check("full_qcount_after_ignored", q_count, 4);
    exp_q = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    check("full_rdata0", rdata, exp_q[0]);
    for (int i = 1; i < 5; i++) begin
      do_pop();
      wait_done(cyc);
      check("full_pop_to_done", cyc, 9);
      check("full_rdata", rdata, exp_q[i]);
    end
    do_pop();
    wait_idle();
    check("full_drained", q_count, 0);
    push(1'b0, 8'd5, 32'h0);
    wait_done(cyc);
    check("full_no_overwrite", rdata, 32'hDEADBEEF);
    do_pop();

    // Reset during ACCESS with another request queued.
    push(1'b0, 8'd5, 32'h0);
    push(1'b0, 8'd3, 32'h0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #2;
    check("mid_rst_done", done, 0);
    check("mid_rst_rvalid", rdata_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_qcount", q_count, 0);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    check("post_rst_no_done", ndone, 0);
    check("post_rst_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
